run_ctl: RTL and testbench
==========================

# run_ctl

Run controller sitting between the harness and the core `top`. It owns the core's `reset` line and start PC, and sequences each program run: it holds the core in reset, releases it, and counts cycles until the core raises `done`. It then reports completion, cycle count and timeout status. It replaces hand-pulsed core reset and `wait(done)` with one deterministic, cycle-counted handshake, so programs 1–3 run back-to-back under a single controller.

## Interface
- `PC_W`, 10: width of core start PC.
- `PROG1_PC`, 0: start PC for program 1 (multiply).
- `PROG2_PC`, 0: start PC for program 2 (pattern search).
- `PROG3_PC`, 0: start PC for program 3 (min pair distance).
- `RESET_CYCLES`, 2: cycles the core is held in reset per run (≥1).
- `TIMEOUT`, 16'd50000: max RUN cycles before abort (1..65535).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low controller reset.
- `start`  in  1  run request, sampled each cycle; ignored unless state is IDLE or DONE.
- `prog_sel`  in  2  program number 1..3, latched with `start`.
- `abort`  in  1  cancel current run.
- `core_done`  in  1  `done` from core.
- `core_reset`  out  1  to core `reset`, active-high.
- `start_pc`  out  PC_W  core entry PC.
- `busy`  out  1  high in RESET or RUN.
- `run_done`  out  1  level; high in DONE.
- `done_pulse`  out  1  one-cycle pulse on entry to DONE.
- `timed_out`  out  1  last run ended by timeout.
- `bad_prog`  out  1  last `start` had `prog_sel` = 0.
- `cycle_ct`  out  16  RUN cycles of last or current run.

## Operation
- States: IDLE, RESET, RUN, DONE.
- Controller reset (`reset`=0 at an edge): state IDLE, `core_reset`=1, `start_pc`=0, `busy`=0, `run_done`=0, `done_pulse`=0, `timed_out`=0, `bad_prog`=0, `cycle_ct`=0. This overrides every other input, mid-run included.
- IDLE: `core_reset`=1.
  - On `start` with `prog_sel` ∈ 1..3: latch the matching PROGn_PC into `start_pc`, clear `cycle_ct`, `timed_out` and `bad_prog`, go to RESET.
  - On `start` with `prog_sel`=0: set `bad_prog`, go directly to DONE with `cycle_ct`=0.
- RESET: `core_reset`=1 for exactly RESET_CYCLES cycles (internal down-counter), then go to RUN. `core_done` is ignored here.
- RUN: `core_reset`=0. Each RUN cycle, `cycle_ct` increments. If `core_done`=1 in RUN cycle n, go to DONE with `cycle_ct`=n.
- Timeout: if RUN cycle n = TIMEOUT and `core_done`=0, go to DONE with `timed_out`=1 and `core_reset` reasserted. `core_done` wins if both occur in the same cycle. `cycle_ct` never exceeds TIMEOUT, so it never wraps.
- DONE:
  - `run_done`=1.
  - `core_reset`=0 after normal completion, so core state and memory stay intact for readback.
  - `core_reset`=1 after timeout or `bad_prog`.
  - `start` begins a new run exactly as from IDLE.
- `abort` in RESET or RUN: go to IDLE next cycle with `core_reset`=1. `cycle_ct` holds its value; no `done_pulse`. `abort` in IDLE or DONE has no effect. `abort` and `start` together in DONE: `abort` is ignored and `start` is taken.
- `start` while `busy` is ignored, with no latching and no queuing.
- `prog_sel` is sampled only on an accepted `start`.

## Timing
- All outputs are registered; they update only on rising `clk`.
- `start` accepted at edge k:
  - `busy`=1 and `start_pc` valid from k.
  - `core_reset` stays 1 through edge k+RESET_CYCLES.
  - `core_reset` falls at edge k+RESET_CYCLES; first RUN cycle follows.
- `core_done` sampled high at the edge ending RUN cycle n: `run_done`, `done_pulse`=1 and `busy`=0 at that same edge. `done_pulse` clears at the next edge.
- Minimum run is RESET_CYCLES+1 cycles from start to `run_done`.
- DONE → new start: `run_done` drops at the accepting edge.

## Test plan
- Reset, then `start`, `prog_sel`=1, RESET_CYCLES=2; core raises `done` after 37 RUN cycles.
  - `core_reset` high for exactly 2 cycles after accept.
  - `start_pc`=PROG1_PC.
  - `run_done`=1, `cycle_ct`=37, one `done_pulse`.
- TIMEOUT=100, `core_done` held 0: DONE after 100 RUN cycles with `timed_out`=1, `cycle_ct`=100, `core_reset`=1.
- `core_done` first rises in RUN cycle 100 with TIMEOUT=100: `timed_out`=0, `cycle_ct`=100.
- `start` pulsed during RUN with `prog_sel`=3: ignored, `start_pc` unchanged. Then `abort`: IDLE next cycle, `core_reset`=1, no `done_pulse`.
- `prog_sel`=0 with `start`: DONE next cycle, `bad_prog`=1, `cycle_ct`=0, `core_reset`=1.
- Back-to-back programs 1, 2, 3, each started in DONE:
  - `cycle_ct` cleared per run.
  - `start_pc` follows PROG1/2/3_PC.
  - `reset` pulled low mid-RUN returns all outputs to reset values at that edge.

Source files
------------

// File: rtl/run_ctl.sv
// Run controller for the core: holds it in reset, releases it, counts RUN cycles
// until core_done or timeout, then reports completion status with registered outputs.
module run_ctl #(
  parameter int              PC_W         = 10,
  parameter logic [PC_W-1:0] PROG1_PC     = '0,
  parameter logic [PC_W-1:0] PROG2_PC     = '0,
  parameter logic [PC_W-1:0] PROG3_PC     = '0,
  parameter int              RESET_CYCLES = 2,
  parameter logic [15:0]     TIMEOUT      = 16'd50000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      prog_sel,
  input  logic            abort,
  input  logic            core_done,
  output logic            core_reset,
  output logic [PC_W-1:0] start_pc,
  output logic            busy,
  output logic            run_done,
  output logic            done_pulse,
  output logic            timed_out,
  output logic            bad_prog,
  output logic [15:0]     cycle_ct
);

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_e;

  state_e          state_q;
  logic [RC_W-1:0] rst_cnt_q;
  logic            core_reset_q, busy_q, run_done_q, done_pulse_q, timed_out_q, bad_prog_q;
  logic [PC_W-1:0] start_pc_q;
  logic [15:0]     cycle_ct_q, cycle_ct_d;
  logic [PC_W-1:0] sel_pc;

  assign cycle_ct_d = cycle_ct_q + 16'd1;

  always_comb begin
    case (prog_sel)
      2'd2:    sel_pc = PROG2_PC;
      2'd3:    sel_pc = PROG3_PC;
      default: sel_pc = PROG1_PC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= '0;
      core_reset_q <= 1'b1;
      start_pc_q   <= '0;
      busy_q       <= 1'b0;
      run_done_q   <= 1'b0;
      done_pulse_q <= 1'b0;
      timed_out_q  <= 1'b0;
      bad_prog_q   <= 1'b0;
      cycle_ct_q   <= '0;
    end else begin
      done_pulse_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            cycle_ct_q   <= '0;
            timed_out_q  <= 1'b0;
            core_reset_q <= 1'b1;
            if (prog_sel == 2'd0) begin
              // Invalid program: report immediately, core stays in reset
              state_q      <= S_DONE;
              bad_prog_q   <= 1'b1;
              run_done_q   <= 1'b1;
              done_pulse_q <= 1'b1;
            end else begin
              state_q    <= S_RESET;
              start_pc_q <= sel_pc;
              bad_prog_q <= 1'b0;
              run_done_q <= 1'b0;
              busy_q     <= 1'b1;
              rst_cnt_q  <= RC_LOAD;
            end
          end
        end
        S_RESET: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (rst_cnt_q == '0) begin
            state_q      <= S_RUN;
            core_reset_q <= 1'b0;
          end else begin
            rst_cnt_q <= rst_cnt_q - RC_W'(1);
          end
        end
        S_RUN: begin
          if (abort) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            core_reset_q <= 1'b1;
          end else begin
            cycle_ct_q <= cycle_ct_d;
            // core_done wins over timeout; a timed-out core is put back in reset
            if (core_done || cycle_ct_d == TIMEOUT) begin
              state_q      <= S_DONE;
              busy_q       <= 1'b0;
              run_done_q   <= 1'b1;
              done_pulse_q <= 1'b1;
              timed_out_q  <= ~core_done;
              core_reset_q <= ~core_done;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_reset = core_reset_q;
  assign start_pc   = start_pc_q;
  assign busy       = busy_q;
  assign run_done   = run_done_q;
  assign done_pulse = done_pulse_q;
  assign timed_out  = timed_out_q;
  assign bad_prog   = bad_prog_q;
  assign cycle_ct   = cycle_ct_q;

endmodule

// File: tb/tb_run_ctl.sv
// Bench for run_ctl: vector table, directed multi-cycle sequences and a randomized
// run, all checked against an elapsed-time behavioural model.
module tb_run_ctl;
  localparam int RC  = 2;
  localparam int TMO = 100;
  localparam logic [9:0] P1 = 10'h011, P2 = 10'h122, P3 = 10'h233;

  logic clk = 1'b0;
  logic reset, start, abort, core_done;
  logic [1:0] prog_sel;
  logic core_reset, busy, run_done, done_pulse, timed_out, bad_prog;
  logic [9:0] start_pc;
  logic [15:0] cycle_ct;

  int n_cmp = 0, n_bad = 0, n_pulse = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  run_ctl #(.PC_W(10), .PROG1_PC(P1), .PROG2_PC(P2), .PROG3_PC(P3),
            .RESET_CYCLES(RC), .TIMEOUT(16'(TMO))) dut (
    .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel), .abort(abort),
    .core_done(core_done), .core_reset(core_reset), .start_pc(start_pc), .busy(busy),
    .run_done(run_done), .done_pulse(done_pulse), .timed_out(timed_out),
    .bad_prog(bad_prog), .cycle_ct(cycle_ct));

  function automatic int pc_of(int p);
    return (p == 1) ? int'(P1) : (p == 2) ? int'(P2) : int'(P3);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model: tracks edges elapsed since an accepted start rather than explicit states.
  int  e_busy = 0, e_rd = 0, e_dp = 0, e_to = 0, e_bad = 0, e_ct = 0, e_pc = 0, e_cr = 1;
  bit  inflight = 0;
  int  age = 0, n = 0;

  always @(posedge clk) begin
    if (!reset) begin
      e_busy = 0; e_rd = 0; e_dp = 0; e_to = 0; e_bad = 0; e_ct = 0; e_pc = 0; e_cr = 1;
      inflight = 0; age = 0;
    end else begin
      e_dp = 0;
      if (inflight) begin
        if (abort) begin
          inflight = 0; e_busy = 0; e_cr = 1;
        end else begin
          age++;
          if (age == RC) e_cr = 0;
          else if (age > RC) begin
            n = age - RC;
            e_ct = n;
            if (core_done || n == TMO) begin
              inflight = 0; e_busy = 0; e_rd = 1; e_dp = 1;
              e_to = core_done ? 0 : 1;
              e_cr = core_done ? 0 : 1;
            end
          end
        end
      end else if (start) begin
        e_ct = 0; e_to = 0; e_cr = 1;
        if (prog_sel == 0) begin
          e_bad = 1; e_rd = 1; e_dp = 1;
        end else begin
          e_bad = 0; e_rd = 0; e_busy = 1; e_pc = pc_of(prog_sel);
          inflight = 1; age = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl.busy", busy, e_busy);
      chk("mdl.run_done", run_done, e_rd);
      chk("mdl.done_pulse", done_pulse, e_dp);
      chk("mdl.timed_out", timed_out, e_to);
      chk("mdl.bad_prog", bad_prog, e_bad);
      chk("mdl.cycle_ct", cycle_ct, e_ct);
      chk("mdl.start_pc", start_pc, e_pc);
      chk("mdl.core_reset", core_reset, e_cr);
      if (done_pulse) n_pulse++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int p);
    start = 1; prog_sel = 2'(p); step(); start = 0;
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  typedef struct {
    logic rst_n, st; logic [1:0] ps; logic ab, cd;
    int busy, rd, dp, cr, to, bad, ct, pc;
  } vec_t;
  vec_t tbl[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int p0, p1;
    reset = 0; start = 0; prog_sel = 0; abort = 0; core_done = 0;
    //           rst st ps ab cd busy rd dp cr to bad ct pc
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 2, 0, 0, 1, 0, 0, 1, 0, 0, 0, P2};
    tbl[3]  = '{1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, P2};
    tbl[4]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, P2};
    tbl[5]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, P2};
    tbl[6]  = '{1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 2, P2};
    tbl[7]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, P2};
    tbl[8]  = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, P2};
    tbl[9]  = '{1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, P2};
    tbl[10] = '{1, 1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, P1};
    tbl[11] = '{1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, P1};
    tbl[12] = '{1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, P1};
    for (int i = 0; i < 13; i++) begin
      reset = tbl[i].rst_n; start = tbl[i].st; prog_sel = tbl[i].ps;
      abort = tbl[i].ab; core_done = tbl[i].cd;
      step();
      chk($sformatf("vec%0d.busy", i), busy, tbl[i].busy);
      chk($sformatf("vec%0d.run_done", i), run_done, tbl[i].rd);
      chk($sformatf("vec%0d.done_pulse", i), done_pulse, tbl[i].dp);
      chk($sformatf("vec%0d.core_reset", i), core_reset, tbl[i].cr);
      chk($sformatf("vec%0d.timed_out", i), timed_out, tbl[i].to);
      chk($sformatf("vec%0d.bad_prog", i), bad_prog, tbl[i].bad);
      chk($sformatf("vec%0d.cycle_ct", i), cycle_ct, tbl[i].ct);
      chk($sformatf("vec%0d.start_pc", i), start_pc, tbl[i].pc);
      if (i == 0) chk_en = 1;
    end
    start = 0; abort = 0; core_done = 0;

    // program 1, done in RUN cycle 37
    p0 = n_pulse;
    do_start(1);
    chk("p1.cr_accept", core_reset, 1);
    chk("p1.pc", start_pc, P1);
    step(); chk("p1.cr_k1", core_reset, 1);
    step(); chk("p1.cr_k2", core_reset, 0);
    steps(36);
    chk("p1.not_done", run_done, 0);
    core_done = 1; step(); core_done = 0;
    chk("p1.run_done", run_done, 1);
    chk("p1.cycle_ct", cycle_ct, 37);
    chk("p1.core_reset", core_reset, 0);
    step();
    chk("p1.one_pulse", n_pulse - p0, 1);

    // timeout at 100 with core_done held low
    do_start(1); steps(2); steps(99);
    chk("to.at99_rd", run_done, 0);
    chk("to.at99_ct", cycle_ct, 99);
    step();
    chk("to.run_done", run_done, 1);
    chk("to.timed_out", timed_out, 1);
    chk("to.cycle_ct", cycle_ct, 100);
    chk("to.core_reset", core_reset, 1);

    // core_done first rises in RUN cycle 100
    do_start(2); steps(2); steps(99);
    core_done = 1; step(); core_done = 0;
    chk("d100.timed_out", timed_out, 0);
    chk("d100.cycle_ct", cycle_ct, 100);
    chk("d100.core_reset", core_reset, 0);

    // start during RUN is ignored, then abort
    do_start(1); steps(2); steps(5);
    p1 = n_pulse;
    do_start(3);
    chk("ign.pc", start_pc, P1);
    chk("ign.busy", busy, 1);
    abort = 1; step(); abort = 0;
    chk("ab.busy", busy, 0);
    chk("ab.core_reset", core_reset, 1);
    chk("ab.run_done", run_done, 0);
    chk("ab.cycle_ct", cycle_ct, 6);
    step();
    chk("ab.no_pulse", n_pulse - p1, 0);

    // bad program number
    do_start(0);
    chk("bad.run_done", run_done, 1);
    chk("bad.bad_prog", bad_prog, 1);
    chk("bad.cycle_ct", cycle_ct, 0);
    chk("bad.core_reset", core_reset, 1);

    // back-to-back 1,2,3 started from DONE; reset mid-RUN on the third
    for (int p = 1; p <= 3; p++) begin
      do_start(p);
      chk($sformatf("b2b%0d.ct_clr", p), cycle_ct, 0);
      chk($sformatf("b2b%0d.pc", p), start_pc, pc_of(p));
      chk($sformatf("b2b%0d.rd_drop", p), run_done, 0);
      steps(2);
      if (p < 3) begin
        steps(2 + p);
        core_done = 1; step(); core_done = 0;
        chk($sformatf("b2b%0d.ct", p), cycle_ct, 3 + p);
        chk($sformatf("b2b%0d.rd", p), run_done, 1);
      end else begin
        steps(5);
        reset = 0; step(); reset = 1;
        chk("rst.core_reset", core_reset, 1);
        chk("rst.start_pc", start_pc, 0);
        chk("rst.busy", busy, 0);
        chk("rst.cycle_ct", cycle_ct, 0);
        chk("rst.run_done", run_done, 0);
      end
    end

    // randomized traffic against the model
    for (int seg = 0; seg < 6; seg++) begin
      int dmod;
      dmod = (seg % 2 == 0) ? 16 : 256;
      for (int c = 0; c < 500; c++) begin
        reset     = ($urandom_range(199) != 0);
        start     = ($urandom_range(7) == 0);
        prog_sel  = 2'($urandom_range(3));
        abort     = ($urandom_range(31) == 0);
        core_done = ($urandom_range(dmod - 1) == 0);
        step();
      end
    end
    reset = 1; start = 0; abort = 0; core_done = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
